// File: rtl/lenet_pkg.sv
// Shared LeNet datapath definitions: pixel width, per-layer feature-map
// geometry and the signed-max helper used by the pooling stages.
package lenet_pkg;

    localparam int PIX_WIDTH   = 8;

    // conv1 produces 24x24 maps, conv2 produces 8x8 maps
    localparam int CONV1_OUT_W = 24;
    localparam int CONV1_OUT_H = 24;
    localparam int CONV2_OUT_W = 8;
    localparam int CONV2_OUT_H = 8;

    // Two's-complement maximum; on a tie either operand is the answer.
    function automatic logic [PIX_WIDTH-1:0] smax(
        input logic [PIX_WIDTH-1:0] a,
        input logic [PIX_WIDTH-1:0] b
    );
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_line_buf.sv
// Half-row buffer of horizontal pair maxima for the 2x2 pooling stage.
// Synchronous write, asynchronous read, so it can later be replaced by a
// RAM macro with the same write-before-read usage pattern.
module maxpool_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 12,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Contents are never reset: every entry is written on an even row
    // before the following odd row reads it.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store a pair maximum at the column-pair address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pooling stage with valid/ready on both
// sides. Pixels arrive in raster order; one pooled pixel leaves per window,
// with out_last marking the final window of each frame.
// Optional build macro MAXPOOL_FUSED_RELU_EN clamps negative results to 0.
module maxpool2x2_stream
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_WIDTH,
    parameter int IMG_W      = CONV1_OUT_W,
    parameter int IMG_H      = CONV1_OUT_H
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int CW       = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [CW-1:0]         col_cnt_reg, col_cnt_next;
    logic [RW-1:0]         row_cnt_reg, row_cnt_next;
    logic [DATA_WIDTH-1:0] pair_reg, pair_next;
    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                  out_valid_reg, out_valid_next;
    logic                  out_last_reg, out_last_next;

    logic                  accept;
    logic                  consume;
    logic                  col_last;
    logic                  row_last;
    logic [AW-1:0]         lb_addr;
    logic                  lb_we;
    logic [DATA_WIDTH-1:0] lb_rd_data;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] pool_max;
    logic [DATA_WIDTH-1:0] pool_val;

    // Input stalls only while a result is held by downstream backpressure
    assign in_ready = ~out_valid_reg | out_ready;
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid_reg & out_ready;

    assign col_last = (col_cnt_reg == CW'(IMG_W - 1));
    assign row_last = (row_cnt_reg == RW'(IMG_H - 1));
    assign lb_addr  = AW'(col_cnt_reg >> 1);
    assign lb_we    = accept & col_cnt_reg[0] & ~row_cnt_reg[0];

    // The package helper is fixed at the LeNet pixel width; other widths
    // fall back to an equivalent local comparison.
    generate
        if (DATA_WIDTH == PIX_WIDTH) begin : g_pkg_max
            assign pair_max = smax(pair_reg, in_data);
            assign pool_max = smax(lb_rd_data, pair_max);
        end else begin : g_local_max
            assign pair_max = ($signed(pair_reg) >= $signed(in_data)) ? pair_reg : in_data;
            assign pool_max = ($signed(lb_rd_data) >= $signed(pair_max)) ? lb_rd_data : pair_max;
        end
    endgenerate

`ifdef MAXPOOL_FUSED_RELU_EN
    assign pool_val = pool_max[DATA_WIDTH-1] ? '0 : pool_max;
`else
    assign pool_val = pool_max;
`endif

    maxpool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LB_DEPTH),
        .AW         (AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_we),
        .addr    (lb_addr),
        .wr_data (pair_max),
        .rd_data (lb_rd_data)
    );

    // Next-state: raster counters, pair capture and output register load/clear
    always_comb begin
        col_cnt_next   = col_cnt_reg;
        row_cnt_next   = row_cnt_reg;
        pair_next      = pair_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;

        if (consume) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end

        if (accept) begin
            if (col_last) begin
                col_cnt_next = '0;
                row_cnt_next = row_last ? '0 : row_cnt_reg + 1'b1;
            end else begin
                col_cnt_next = col_cnt_reg + 1'b1;
            end

            if (!col_cnt_reg[0]) begin
                pair_next = in_data;
            end else if (row_cnt_reg[0]) begin
                // A load in the same cycle as a consume overrides the clear
                out_data_next  = pool_val;
                out_valid_next = 1'b1;
                out_last_next  = row_last & col_last;
            end
        end
    end

    // State registers, cleared asynchronously so a mid-frame reset drops the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            pair_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            col_cnt_reg   <= col_cnt_next;
            row_cnt_reg   <= row_cnt_next;
            pair_reg      <= pair_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream on a 4x4 frame of int8 pixels.
module tb_maxpool2x2_stream;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0: always ready, 1: held low, 2: random 50%

    logic [7:0] stim [64];
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];
    logic [7:0] got_q[$];
    bit         got_last_q[$];

    typedef struct {
        string name;
        byte   px  [16];
        byte   expv[4];
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    maxpool2x2_stream #(
        .DATA_WIDTH (8),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    function automatic byte post(input byte v);
`ifdef MAXPOOL_FUSED_RELU_EN
        return (v < 0) ? 8'sd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic byte bmax(input byte a, input byte b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: a transfer sampled here completes at the next posedge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_last_q.push_back(out_last);
        end
    end

    task automatic drive(input int n, input int bubble);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 4000) begin
            @(posedge clk);
            #1;
            in_valid = (bubble == 0) ? 1'b1 : ($urandom_range(0, 99) >= bubble);
            in_data  = stim[i];
            @(negedge clk);
            if (in_valid && in_ready) i++;
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout accepted=%0d required=%0d", i, n);
        end
    endtask

    task automatic collect(input string tag, input int n);
        int guard = 0;
        while (got_q.size() < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (12) @(negedge clk);
        check({tag, "_count"}, got_q.size(), n);
        for (int k = 0; k < n && k < got_q.size(); k++) begin
            $display("%s out %0d data=%0d last=%0b expected data=%0d last=%0b",
                     tag, k, $signed(got_q[k]), got_last_q[k], $signed(exp_q[k]), exp_last_q[k]);
            check({tag, "_data"}, 32'(got_q[k]), 32'(exp_q[k]));
            check({tag, "_last"}, 32'(got_last_q[k]), 32'(exp_last_q[k]));
        end
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < 16; i++) stim[i] = vecs[v].px[i];
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(vecs[v].expv[k]);
            exp_last_q.push_back(k == 3);
        end
    endtask

    initial begin
        // Directed frames with hand-computed pooled outputs
        for (int i = 0; i < 16; i++) begin
            vecs[0].px[i] = byte'(i + 1);
            vecs[1].px[i] = 8'sd0;
            vecs[2].px[i] = 8'sd127;
            vecs[3].px[i] = -8'sd128;
        end
        vecs[0].name = "raster";
        vecs[0].expv = '{8'sd6, 8'sd8, 8'sd14, 8'sd16};
        vecs[1].name = "signed";
        vecs[1].px[0] = -8'sd5;
        vecs[1].px[1] = -8'sd3;
        vecs[1].px[4] = -8'sd7;
        vecs[1].px[5] = -8'sd128;
        vecs[1].expv = '{post(-8'sd3), 8'sd0, 8'sd0, 8'sd0};
        vecs[2].name = "tie_max";
        vecs[2].expv = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        vecs[3].name = "tie_min";
        vecs[3].expv = '{post(-8'sd128), post(-8'sd128), post(-8'sd128), post(-8'sd128)};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Table-driven frames, full throughput
        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            drive(16, 0);
            collect(vecs[v].name, 4);
        end

        // Backpressure: stall on the first output for 10 cycles
        load_vec(0);
        ready_mode = 1;
        fork
            drive(16, 0);
            begin
                int g = 0;
                while (!out_valid && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                check("bp_first_valid", out_valid, 1);
                repeat (10) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_hold_data", out_data, 6);
                    check("bp_hold_valid", out_valid, 1);
                end
                ready_mode = 0;
            end
        join
        collect("bp", 4);

        // Reset after 7 accepted pixels, then a clean frame
        load_vec(0);
        exp_q.delete();
        exp_last_q.delete();
        drive(7, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst7_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        got_last_q.delete();
        load_vec(0);
        drive(16, 0);
        collect("after_rst7", 4);

        // Reset while a pooled result is pending under backpressure
        ready_mode = 1;
        drive(6, 0);
        @(negedge clk);
        check("pend_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        got_q.delete();
        got_last_q.delete();
        load_vec(0);
        drive(16, 0);
        collect("after_rst6", 4);

        // Two back-to-back random frames with random bubbles and backpressure
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom_range(0, 255));
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < H / 2; r++) begin
                for (int c = 0; c < W / 2; c++) begin
                    int  b;
                    byte m;
                    b = f * W * H + 2 * r * W + 2 * c;
                    m = bmax(bmax(byte'(stim[b]), byte'(stim[b + 1])),
                             bmax(byte'(stim[b + W]), byte'(stim[b + W + 1])));
                    exp_q.push_back(post(m));
                    exp_last_q.push_back(r == H / 2 - 1 && c == W / 2 - 1);
                end
            end
        end
        ready_mode = 2;
        drive(32, 50);
        collect("rand", 8);
        ready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2/stride-2 max-pooling stage between a convolution output stream and the next layer's input FIFO in the LeNet datapath.
- Consumes one signed feature-map pixel per accepted beat in raster order (row-major, one channel per frame).
- Emits one pooled pixel per 2x2 window over valid/ready handshakes.
- Keeps a half-row buffer of horizontal pair maxima, so each window is produced without re-reading the frame.

Parameters:
- DATA_WIDTH, 8, pixel width, two's-complement signed.
- IMG_W, 24, input frame width in pixels; must be even and >= 2.
- IMG_H, 24, input frame height in pixels; must be even and >= 2.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  input pixel, signed.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  stage accepts a beat this cycle.
- out_data  output  DATA_WIDTH  pooled pixel, signed.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  qualifies the final pooled pixel of a frame.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n. All registers clear on rst_n low regardless of clk.
- Reset values:
  - out_valid=0, out_data=0, out_last=0.
  - col_cnt=0, row_cnt=0, pair_reg=0.
  - in_ready=1 immediately after reset.
  - Line buffer contents are not reset; they are always written before they are read.
- Handshakes:
  - in_ready = ~out_valid | out_ready, combinational. This applies to every beat, not only window-completing beats.
  - A beat is accepted when in_valid & in_ready.
  - An output is consumed when out_valid & out_ready.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Counters:
  - col_cnt advances 0..IMG_W-1 on each accepted beat.
  - On wrap, row_cnt advances 0..IMG_H-1.
  - After row IMG_H-1 col IMG_W-1, both counters return to 0; the next frame follows back-to-back with no gap.
- Datapath on each accepted beat, with x = in_data and c = col_cnt>>1:
  - Even col: pair_reg <= x.
  - Odd col: m = smax(pair_reg, x).
    - Even row: lb[c] <= m.
    - Odd row: out_data <= smax(lb[c], m); out_valid <= 1; out_last <= (row_cnt==IMG_H-1 && col_cnt==IMG_W-1).
- smax is a signed comparison. Equal operands return that value. No width growth; output width = DATA_WIDTH.
- Latency: out_valid rises the cycle after the 4th pixel of a window (odd row, odd col) is accepted.
- out_valid clear: when a consume occurs and no new output is loaded that cycle, out_valid <= 0 and out_last <= 0. A simultaneous consume and load replaces the output register, so full throughput is sustained.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0; counters and buffers are frozen.
- Bubbles: in_valid=0 cycles change no state.
- Reset mid-frame: the partial frame is discarded, no output is produced for it, and the next accepted beat is treated as row 0 col 0.
- Throughput: IMG_W*IMG_H input beats per frame produce (IMG_W/2)*(IMG_H/2) outputs.

Optional Feature:
- Macro: MAXPOOL_FUSED_RELU_EN.
- Defined: the value loaded into out_data is clamped to 0 when negative (fused ReLU). Latency and handshake are unchanged.
- Undefined: out_data is the raw signed maximum, and negative values pass through.

Decomposition:
- Shared package (lenet_pkg):
  - Pixel DATA_WIDTH constant.
  - Per-layer IMG_W/IMG_H constants: conv1 output 24x24, conv2 output 8x8.
  - Signed-max helper function, reused by other pooling stages.
- One natural sub-module, maxpool_line_buf: a synchronous-write / asynchronous-read array of IMG_W/2 entries of DATA_WIDTH bits, with write enable and address c. It can later be swapped for a RAM macro.
- Counters, pair_reg and the output register are flops with the same asynchronous active-low reset as the rest of the datapath.

Test Plan:
- Setup: IMG_W=4, IMG_H=4, DATA_WIDTH=8. Feed 1..16 raster with in_valid=1 and out_ready=1. Expect outputs 6, 8, 14, 16 in that order; out_last=1 only with 16; exactly 4 outputs.
- Signed values: first window row0 = {-5, -3}, row1 = {-7, -128}. Expect out_data = -3 (0xFD). With MAXPOOL_FUSED_RELU_EN defined, expect 0.
- Backpressure: hold out_ready=0 after the first output (6) appears. Expect in_ready=0, out_data stable at 6 for 10 cycles, and no pixel lost. Release, and expect the remaining outputs to be 8, 14, 16.
- Random bubbles: in_valid and out_ready random at 50%, two back-to-back frames of random int8 data. Expect output to match a reference model, and out_last exactly once per frame on the 4th output.
- Reset mid-frame: assert rst_n=0 for 1 cycle after 7 pixels are accepted. Expect out_valid=0 immediately. Then feed a full 1..16 frame and expect 6, 8, 14, 16.
- Tie and extremes: window all 127, expect 127; window {-128, -128, -128, -128}, expect -128.
